// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, FSM states and request record for the Wishbone pipelined master
package wb_pkg;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;
    typedef enum logic [1:0] {IDLE, ACTIVE, ABORT} state_t;
    typedef struct packed {
        logic              we;
        logic [AW_DEF-1:0] adr;
        logic [DW_DEF-1:0] dat;
    } req_t;
endpackage

// File: rtl/wb_credit_cnt.sv
// wb_credit_cnt: outstanding-transfer counter; saturates at MAX, nets simultaneous issue/ack, ignores spurious acks
module wb_credit_cnt #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_n
);
    logic inc_ok, dec_ok;
    assign inc_ok = inc && cnt < W'(MAX);
    // an ack is only meaningful against something already out or issuing now
    assign dec_ok = dec && (cnt != '0 || inc_ok);
    always_comb begin
        cnt_n = clr ? '0 : (inc_ok == dec_ok) ? cnt : inc_ok ? cnt + W'(1) : cnt - W'(1);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else          cnt <= cnt_n;
    end
endmodule

// File: rtl/wb_pipe_master.sv
// wb_pipe_master: bridges the core request/response port onto pipelined Wishbone B4 as sole master,
// tracking outstanding transfers and aborting a hung cycle after TIMEOUT ack-less cycles.
module wb_pipe_master import wb_pkg::*; #(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_adr,
    input  logic [DW-1:0] req_dat,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_dat,
    output logic          rsp_err,
    output logic          wb_cyc,
    output logic          wb_stb,
    output logic          wb_we,
    output logic [AW-1:0] wb_adr,
    output logic [DW-1:0] wb_dat_m,
    input  logic [DW-1:0] wb_dat_s,
    input  logic          wb_stall,
    input  logic          wb_ack,
    output logic          busy
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_n;
    logic [CW-1:0] out_cnt, out_cnt_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic [CW:0]   credit;
    logic          stb_n, issue, accept, ack_ok, to_hit;

    assign issue     = wb_stb && !wb_stall;
    assign credit    = {1'b0, out_cnt} + (CW+1)'(wb_stb);
    // held low during reset so every output reads zero while reset_n is asserted
    assign req_ready = reset_n && (!wb_stb || !wb_stall) && credit < (CW+1)'(MAX_OUT) && state != ABORT;
    assign accept    = req_valid && req_ready;
    assign ack_ok    = wb_ack && state == ACTIVE && (out_cnt != '0 || issue);
    assign to_hit    = state == ACTIVE && !wb_ack && !issue && to_cnt == TW'(TIMEOUT - 1);
    assign busy      = wb_cyc || wb_stb || state != IDLE;

    wb_credit_cnt #(.MAX(MAX_OUT), .W(CW)) u_credit (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (to_hit),
        .inc    (issue),
        .dec    (ack_ok),
        .cnt    (out_cnt),
        .cnt_n  (out_cnt_n)
    );

    always_comb begin
        stb_n    = to_hit ? 1'b0 : accept ? 1'b1 : issue ? 1'b0 : wb_stb;
        to_cnt_n = (state != ACTIVE || wb_ack || issue) ? '0 : to_cnt + TW'(1);
        state_n  = (state == ABORT) ? IDLE :
                   to_hit           ? ABORT :
                   (state == IDLE)  ? (accept ? ACTIVE : IDLE) :
                   (out_cnt_n == '0 && !stb_n) ? IDLE : ACTIVE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wb_stb    <= 1'b0;
            wb_cyc    <= 1'b0;
            wb_we     <= 1'b0;
            wb_adr    <= '0;
            wb_dat_m  <= '0;
            to_cnt    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_dat   <= '0;
        end else begin
            state     <= state_n;
            wb_stb    <= stb_n;
            wb_cyc    <= stb_n || out_cnt_n != '0;
            to_cnt    <= to_cnt_n;
            rsp_valid <= ack_ok || to_hit;
            rsp_err   <= to_hit;
            if (accept) begin
                wb_we    <= req_we;
                wb_adr   <= req_adr;
                wb_dat_m <= req_dat;
            end
            if (ack_ok) rsp_dat <= wb_dat_s;
        end
    end
endmodule

// File: tb/tb_wb_pipe_master.sv
// tb_wb_pipe_master: directed scenarios for the Wishbone pipelined master with hand-computed expectations
module tb_wb_pipe_master;
    import wb_pkg::*;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [15:0] req_adr = '0, req_dat = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [15:0] rsp_dat;
    logic        wb_cyc, wb_stb, wb_we;
    logic [15:0] wb_adr, wb_dat_m;
    logic [15:0] wb_dat_s = '0;
    logic        wb_stall = 1'b0, wb_ack = 1'b0;
    logic        busy;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    wb_pipe_master #(.AW(16), .DW(16), .MAX_OUT(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_adr(req_adr), .req_dat(req_dat),
        .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_dat_m(wb_dat_m),
        .wb_dat_s(wb_dat_s), .wb_stall(wb_stall), .wb_ack(wb_ack), .busy(busy)
    );

    task automatic test_reset();
        #1;
        checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL rst_cyc: got %b want 0", wb_cyc); end
        checks++; if (wb_stb !== 1'b0) begin errors++; $display("FAIL rst_stb: got %b want 0", wb_stb); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp: got %b want 0", rsp_valid); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        checks++; if (busy !== 1'b0 || wb_adr !== 16'h0) begin errors++; $display("FAIL rst_busy_adr: got %b/%h want 0/0000", busy, wb_adr); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_adr = 16'h0010;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if (wb_stb !== 1'b1 || wb_cyc !== 1'b1) begin errors++; $display("FAIL rd_stb_cyc: got %b%b want 11", wb_stb, wb_cyc); end
        checks++; if (wb_adr !== 16'h0010 || wb_we !== 1'b0) begin errors++; $display("FAIL rd_adr_we: got %h/%b want 0010/0", wb_adr, wb_we); end
        @(negedge clk);
        wb_ack = 1'b1; wb_dat_s = 16'hBEEF;
        #1;
        checks++; if (wb_stb !== 1'b0 || wb_cyc !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_wait: got stb=%b cyc=%b rsp=%b want 0 1 0", wb_stb, wb_cyc, rsp_valid); end
        @(negedge clk);
        wb_ack = 1'b0; wb_dat_s = 16'h0;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_dat !== 16'hBEEF || rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp: got v=%b d=%h e=%b want 1 beef 0", rsp_valid, rsp_dat, rsp_err); end
        checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL rd_cyc_drop: got %b want 0", wb_cyc); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd_done: got rsp=%b busy=%b want 0 0", rsp_valid, busy); end
    endtask

    task automatic test_back_to_back();
        req_t        tbl [4];
        logic [15:0] sdat [4];
        int          nrsp = 0;
        for (int i = 0; i < 4; i++) begin
            tbl[i]  = '{we: 1'b1, adr: 16'h0020 + 16'(i), dat: 16'h1111 * 16'(i + 1)};
            sdat[i] = 16'hD000 + 16'(i);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_valid = c < 4;
            if (c < 4) {req_we, req_adr, req_dat} = tbl[c];
            wb_ack   = c >= 2 && c <= 5;
            wb_dat_s = (c >= 2 && c <= 5) ? sdat[c-2] : 16'h0;
            #1;
            if (c < 4) begin
                checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready c=%0d: got %b want 1", c, req_ready); end
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (wb_stb !== 1'b1 || {wb_we, wb_adr, wb_dat_m} !== tbl[c-1]) begin
                    errors++; $display("FAIL b2b_issue c=%0d: got stb=%b we=%b adr=%h dat=%h want 1 %b %h %h", c, wb_stb, wb_we, wb_adr, wb_dat_m, tbl[c-1].we, tbl[c-1].adr, tbl[c-1].dat);
                end
            end
            checks++; if (wb_cyc !== (c >= 1 && c <= 5)) begin errors++; $display("FAIL b2b_cyc c=%0d: got %b want %b", c, wb_cyc, c >= 1 && c <= 5); end
            if (c >= 3 && c <= 6) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_dat !== sdat[c-3]) begin errors++; $display("FAIL b2b_rsp c=%0d: got v=%b d=%h want 1 %h", c, rsp_valid, rsp_dat, sdat[c-3]); end
            end
            if (rsp_valid === 1'b1) nrsp++;
        end
        req_valid = 1'b0; wb_ack = 1'b0;
        checks++; if (nrsp != 4) begin errors++; $display("FAIL b2b_rsp_count: got %0d want 4", nrsp); end
    endtask

    task automatic test_stall();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_adr = 16'h0040; req_dat = 16'h5A5A;
        wb_stall = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_adr = 16'h0099; req_dat = 16'hFFFF; req_we = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) @(negedge clk);
            wb_stall = c <= 3;
            #1;
            checks++;
            if (wb_stb !== 1'b1 || wb_adr !== 16'h0040 || wb_dat_m !== 16'h5A5A || wb_we !== 1'b1) begin
                errors++; $display("FAIL stall_hold c=%0d: got stb=%b adr=%h dat=%h we=%b want 1 0040 5a5a 1", c, wb_stb, wb_adr, wb_dat_m, wb_we);
            end
            if (c <= 3) begin
                checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready c=%0d: got %b want 0", c, req_ready); end
            end
        end
        @(negedge clk);
        wb_ack = 1'b1; wb_dat_s = 16'h1234;
        #1;
        checks++; if (wb_stb !== 1'b0) begin errors++; $display("FAIL stall_stb_clear: got %b want 0", wb_stb); end
        @(negedge clk);
        wb_ack = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_dat !== 16'h1234) begin errors++; $display("FAIL stall_rsp: got v=%b d=%h want 1 1234", rsp_valid, rsp_dat); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0 || wb_cyc !== 1'b0) begin errors++; $display("FAIL stall_single: got rsp=%b cyc=%b want 0 0", rsp_valid, wb_cyc); end
    endtask

    task automatic test_credit();
        int nacc = 0, niss = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b0; req_adr = 16'h0100 + 16'(nacc);
            #1;
            if (wb_stb === 1'b1) begin
                checks++; if (wb_adr !== 16'h0100 + 16'(niss)) begin errors++; $display("FAIL credit_adr: got %h want %h", wb_adr, 16'h0100 + 16'(niss)); end
                niss++;
            end
            if (req_ready === 1'b1) nacc++;
        end
        checks++; if (niss != 4 || nacc != 4) begin errors++; $display("FAIL credit_count: got issues=%0d accepts=%0d want 4 4", niss, nacc); end
        checks++; if (req_ready !== 1'b0 || wb_cyc !== 1'b1) begin errors++; $display("FAIL credit_full: got ready=%b cyc=%b want 0 1", req_ready, wb_cyc); end
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            req_valid = 1'b0;
            wb_ack = j < 4; wb_dat_s = 16'h00C0 + 16'(j);
            #1;
            if (j >= 1 && j <= 4) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_dat !== 16'h00C0 + 16'(j - 1)) begin errors++; $display("FAIL credit_rsp j=%0d: got v=%b d=%h want 1 %h", j, rsp_valid, rsp_dat, 16'h00C0 + 16'(j - 1)); end
            end
        end
        wb_ack = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || wb_cyc !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL credit_drain: got rsp=%b cyc=%b ready=%b want 0 0 1", rsp_valid, wb_cyc, req_ready); end
    endtask

    task automatic test_timeout();
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_adr = 16'h0077;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if (wb_stb !== 1'b1) begin errors++; $display("FAIL to_issue: got %b want 1", wb_stb); end
        while (n <= 400) begin
            @(negedge clk);
            n++;
            #1;
            if (rsp_valid === 1'b1) break;
        end
        checks++; if (n != TIMEOUT + 1) begin errors++; $display("FAIL to_latency: got %0d cycles want %0d", n, TIMEOUT + 1); end
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL to_err: got v=%b e=%b want 1 1", rsp_valid, rsp_err); end
        checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_abort: got cyc=%b stb=%b ready=%b busy=%b want 0 0 0 1", wb_cyc, wb_stb, req_ready, busy); end
        wb_ack = 1'b1; wb_dat_s = 16'hDEAD;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0 || wb_cyc !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL to_idle: got rsp=%b cyc=%b busy=%b ready=%b want 0 0 0 1", rsp_valid, wb_cyc, busy, req_ready); end
        @(negedge clk);
        wb_ack = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL to_late_ack: got v=%b e=%b want 0 0", rsp_valid, rsp_err); end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_adr = 16'h0200 + 16'(c); req_dat = 16'h7700 + 16'(c);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if (wb_stb !== 1'b1 || wb_cyc !== 1'b1) begin errors++; $display("FAIL rm_busy: got stb=%b cyc=%b want 1 1", wb_stb, wb_cyc); end
        #1;
        reset_n = 1'b0; wb_ack = 1'b1; wb_dat_s = 16'hBAD0;
        #1;
        checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_async: got cyc=%b stb=%b rsp=%b want 0 0 0", wb_cyc, wb_stb, rsp_valid); end
        checks++; if (wb_adr !== 16'h0 || wb_dat_m !== 16'h0 || busy !== 1'b0) begin errors++; $display("FAIL rm_clear: got adr=%h dat=%h busy=%b want 0000 0000 0", wb_adr, wb_dat_m, busy); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1; wb_ack = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_adr = 16'h0001;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if (wb_stb !== 1'b1 || wb_adr !== 16'h0001 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_issue: got stb=%b adr=%h rsp=%b want 1 0001 0", wb_stb, wb_adr, rsp_valid); end
        @(negedge clk);
        wb_ack = 1'b1; wb_dat_s = 16'h0BAD;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_stale: got %b want 0", rsp_valid); end
        @(negedge clk);
        wb_ack = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_dat !== 16'h0BAD || rsp_err !== 1'b0) begin errors++; $display("FAIL rm_rsp: got v=%b d=%h e=%b want 1 0bad 0", rsp_valid, rsp_dat, rsp_err); end
        @(negedge clk);
        #1;
        checks++; if (wb_cyc !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_done: got cyc=%b rsp=%b want 0 0", wb_cyc, rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_stall();
        test_credit();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_pipe_master.md
Name: wb_pipe_master

Overview:
- Bridges the J1 core's simple request/response memory port onto a classic pipelined Wishbone B4 bus as the single bus master.
- Sits directly upstream of the bus and its protocol checker.
- Drives CYC/STB/WE/ADR/DAT and tracks accepted-but-unacknowledged transfers.
- Returns one response per request to the core and aborts hung cycles by timeout.

Parameters:
AW, 16, address width
DW, 16, data width
MAX_OUT, 4, max accepted-but-unacked transfers (power of 2, >=1)
TIMEOUT, 255, cycles of no ACK while outstanding before abort (>=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  core request present
req_ready  out  1  bridge accepts request this cycle
req_we  in  1  1=write, 0=read
req_adr  in  AW  request address
req_dat  in  DW  write data
rsp_valid  out  1  one-cycle response pulse
rsp_dat  out  DW  read data (registered dat_s)
rsp_err  out  1  response is a timeout abort
wb_cyc  out  1  bus cycle
wb_stb  out  1  strobe
wb_we  out  1  write enable
wb_adr  out  AW  address
wb_dat_m  out  DW  master write data
wb_dat_s  in  DW  slave read data
wb_stall  in  1  slave stall
wb_ack  in  1  slave acknowledge
busy  out  1  cycle active or request pending

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, reset_n). While reset_n=0, all outputs and registers are 0 immediately, including adr/dat_m and mid-transfer. First valid edge is the first rising clk after deassertion.
- Request register holds one transfer: stb, we, adr, dat_m.
- Issue: wb_stb=1 while the register holds a transfer; adr/we/dat_m stable while stb=1 and wb_stall=1.
- Accept (core side): req_ready = (!wb_stb || !wb_stall) && (out_cnt + wb_stb < MAX_OUT) && state==ACTIVE_OR_IDLE. req_valid && req_ready loads the register next cycle (stb=1).
- Back-to-back issue with no bubble when stall=0 and credit is available.
- Otherwise stb clears the cycle after stb && !stall.
- Outstanding counter out_cnt, width clog2(MAX_OUT+1):
  - +1 on stb && !stall.
  - -1 on ack.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUT.
  - ACK with out_cnt==0 and no same-cycle issue is spurious: ignored, no response, counter does not wrap.
- wb_cyc = wb_stb || out_cnt!=0, registered. CYC drops the cycle after the last ACK when nothing is pending. No CYC glitch between transfers.
- Response: ack registered. rsp_valid=1 one cycle after each ACK, rsp_dat = dat_s captured at ACK, rsp_err=0. Writes also respond (rsp_dat = captured dat_s, don't-care). Responses are in issue order; there is no response backpressure.
- State machine:
  - IDLE: cyc=0. On accept -> ACTIVE.
  - ACTIVE: cyc=1. When out_cnt becomes 0 with no stb -> IDLE.
  - Timeout -> ABORT.
  - ABORT: one cycle, cyc=0, stb=0, out_cnt=0, req_ready=0. Next state is IDLE.
- Timeout counter:
  - Clears on any ACK, on issue, and in IDLE.
  - Increments in ACTIVE otherwise.
  - On reaching TIMEOUT: enter ABORT. Emit exactly one rsp_valid=1 with rsp_err=1 in the ABORT cycle. All lost transfers are reported by that single error response. A pending stb is dropped.
- ACK arriving in ABORT or IDLE is ignored.
- busy = cyc || stb || state!=IDLE.

Decomposition:
- Shared package wb_pkg: default AW/DW constants, state enum (IDLE, ACTIVE, ABORT), and a request struct (we, adr, dat).
- One natural sub-module, wb_credit_cnt: the up/down outstanding counter with saturation, simultaneous inc/dec, and spurious-ACK guard.
- Timeout and FSM stay in the top.

Test Plan:
- Single read: req adr=0x0010, slave acks next cycle with dat_s=0xBEEF, stall=0 -> stb one cycle, cyc drops after ACK, rsp_valid one cycle after ACK with rsp_dat=0xBEEF, rsp_err=0.
- Burst of 4 writes (adr 0x20..0x23, dat 0x1111..0x4444), no stall -> four consecutive stb cycles, no cyc gap, 4 rsp_valid pulses in order, out_cnt peaks <=2.
- Stall: slave holds stall=1 for 3 cycles on adr=0x0040 -> adr/we/dat_m unchanged for all 4 stb cycles, req_ready=0 during stall, single ACK and single response.
- Credit limit: MAX_OUT=4, slave withholds ACKs -> exactly 4 issues, req_ready=0 afterwards. Release 4 ACKs -> 4 responses, then accepts again.
- Timeout: issue read, never ack -> after 255 idle cycles one ABORT cycle with cyc=0, rsp_valid=1 and rsp_err=1. A late ACK afterwards is ignored, state returns to IDLE.
- Reset mid-burst: reset_n=0 with 2 outstanding -> cyc/stb/rsp_valid=0 immediately. After release, a new read to 0x0001 completes normally with no stale response.
